fft_frame_sequencer: RTL and testbench

- Controller between the I2S double buffer and the FFT input port.
- On each buffer-ready pulse it walks the readable buffer (addresses 0..FRAME_LEN-1). It streams the samples into the FFT sink using a valid/ready handshake with start-of-packet (sop) and end-of-packet (eop) markers.
- Detects overrun: a new buffer becomes ready while a frame is still streaming.
- Keeps frame and overrun statistics for the control/status path.

---
 rtl/fft_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_fft_frame_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Streams a readable double-buffer frame into the FFT sink with sop/eop/err.
// Define FFT_SEQ_BITREV_ADDR_EN to read the buffer in bit-reversed order.
module fft_frame_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int FRAME_LEN  = 512,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic                         i_frame_ready,
    output logic [$clog2(FRAME_LEN)-1:0] o_rd_addr,
    input  logic [DATA_WIDTH-1:0]        i_rd_data,
    output logic                         o_sink_valid,
    input  logic                         i_sink_ready,
    output logic [DATA_WIDTH-1:0]        o_sink_data,
    output logic                         o_sink_sop,
    output logic                         o_sink_eop,
    output logic                         o_sink_err,
    output logic                         o_busy,
    output logic                         o_overrun,
    input  logic                         i_clear_overrun,
    output logic [CNT_WIDTH-1:0]         o_frame_count,
    output logic [CNT_WIDTH-1:0]         o_drop_count
);

    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t state;
    state_t state_nx;

    logic [AW-1:0] idx;
    logic          pending;
    logic          corrupt;
    logic          xfer;
    logic          last_xfer;
    logic          ovr_evt;
    logic          start_req;

    assign start_req = i_frame_ready && i_enable;
    assign xfer      = o_sink_valid && i_sink_ready;
    assign last_xfer = xfer && o_sink_eop;
    // A pulse coinciding with the eop transfer is a normal start, not an overrun
    assign ovr_evt   = (state == STREAM) && i_frame_ready && !last_xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_req) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (last_xfer && !pending && !start_req) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_sink_valid = (state == STREAM);
        o_busy       = (state == STREAM);
        o_sink_sop   = (state == STREAM) && (idx == '0);
        o_sink_eop   = (state == STREAM) && (idx == LAST);
        o_sink_err   = o_sink_eop && corrupt;
        o_sink_data  = i_rd_data;
    end

`ifdef FFT_SEQ_BITREV_ADDR_EN
    always_comb begin
        o_rd_addr = '0;
        for (int i = 0; i < AW; i++) begin
            o_rd_addr[i] = idx[AW-1-i];
        end
    end
`else
    assign o_rd_addr = idx;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            idx           <= '0;
            pending       <= 1'b0;
            corrupt       <= 1'b0;
            o_overrun     <= 1'b0;
            o_frame_count <= '0;
            o_drop_count  <= '0;
        end else begin
            if (last_xfer) begin
                idx <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end

            // Only one frame is ever queued, however many overruns occur
            if (last_xfer) begin
                pending <= 1'b0;
                corrupt <= 1'b0;
            end else if (ovr_evt) begin
                pending <= 1'b1;
                corrupt <= 1'b1;
            end

            if (last_xfer) begin
                o_frame_count <= o_frame_count + 1'b1;
            end

            if (i_clear_overrun) begin
                o_overrun    <= 1'b0;
                o_drop_count <= '0;
            end else if (ovr_evt) begin
                o_overrun <= 1'b1;
                if (o_drop_count != '1) begin
                    o_drop_count <= o_drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer with FRAME_LEN=8.
// Compares every cycle against a frame-level reference model.
module tb_fft_frame_sequencer;

    localparam int DW = 24;
    localparam int L  = 8;
    localparam int CW = 16;

    typedef logic [6+3+DW+2*CW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_enable;
    logic          i_frame_ready;
    logic [2:0]    o_rd_addr;
    logic [DW-1:0] i_rd_data;
    logic          o_sink_valid;
    logic          i_sink_ready;
    logic [DW-1:0] o_sink_data;
    logic          o_sink_sop;
    logic          o_sink_eop;
    logic          o_sink_err;
    logic          o_busy;
    logic          o_overrun;
    logic          i_clear_overrun;
    logic [CW-1:0] o_frame_count;
    logic [CW-1:0] o_drop_count;

    logic [DW-1:0] mem [L];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit m_active;
    int m_beat;
    bit m_queued;
    bit m_bad;
    bit m_ovr;
    int m_frames;
    int m_drops;

    always #5 clk = ~clk;

    assign i_rd_data = mem[o_rd_addr];

    fft_frame_sequencer #(
        .DATA_WIDTH(DW),
        .FRAME_LEN (L),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_frame_ready  (i_frame_ready),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (i_rd_data),
        .o_sink_valid   (o_sink_valid),
        .i_sink_ready   (i_sink_ready),
        .o_sink_data    (o_sink_data),
        .o_sink_sop     (o_sink_sop),
        .o_sink_eop     (o_sink_eop),
        .o_sink_err     (o_sink_err),
        .o_busy         (o_busy),
        .o_overrun      (o_overrun),
        .i_clear_overrun(i_clear_overrun),
        .o_frame_count  (o_frame_count),
        .o_drop_count   (o_drop_count)
    );

    function automatic int addr_of(input int b);
`ifdef FFT_SEQ_BITREV_ADDR_EN
        return ((b & 1) << 2) | (b & 2) | ((b >> 2) & 1);
`else
        return b;
`endif
    endfunction

    function automatic vec_t observe();
        return {o_sink_valid, o_sink_sop, o_sink_eop, o_sink_err,
                o_busy, o_overrun, o_rd_addr, o_sink_data,
                o_frame_count, o_drop_count};
    endfunction

    function automatic vec_t model_out();
        bit v, sop, eop;
        int a;
        v   = m_active;
        sop = m_active && (m_beat == 0);
        eop = m_active && (m_beat == L - 1);
        a   = addr_of(m_beat);
        return {v, sop, eop, eop && m_bad, v, m_ovr, 3'(a), mem[a],
                CW'(m_frames), CW'(m_drops)};
    endfunction

    task automatic model_step();
        bit xfer, last, ev;
        if (reset) begin
            m_active = 0; m_beat = 0; m_queued = 0; m_bad = 0;
            m_ovr = 0; m_frames = 0; m_drops = 0;
        end else begin
            xfer = m_active && i_sink_ready;
            last = xfer && (m_beat == L - 1);
            ev   = m_active && i_frame_ready && !last;
            if (!m_active) begin
                if (i_frame_ready && i_enable) m_active = 1;
            end else if (last) begin
                m_frames++;
                m_beat = 0;
                m_bad  = 0;
                if (m_queued) m_queued = 0;
                else if (!(i_frame_ready && i_enable)) m_active = 0;
            end else if (xfer) begin
                m_beat++;
            end
            if (ev) begin
                m_queued = 1;
                m_bad    = 1;
                m_ovr    = 1;
                if (m_drops < (1 << CW) - 1) m_drops++;
            end
            if (i_clear_overrun) begin
                m_ovr   = 0;
                m_drops = 0;
            end
        end
    endtask

    task automatic drive(input bit fr, en, rdy, clr, rst);
        i_frame_ready   = fr;
        i_enable        = en;
        i_sink_ready    = rdy;
        i_clear_overrun = clr;
        reset           = rst;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < L; i++) mem[i] = DW'($urandom);
    endtask

    task automatic test_reset();
        fill_random();
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom), 1, 1'($urandom), 0, 1);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL reset c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
        end
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < L; i++) mem[i] = DW'(24'h10 + i);
        for (int c = 0; c < 14; c++) begin
            drive(c == 0, 1, 1, 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL single c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
        end
        vectors++;
        if (o_frame_count !== 16'd1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_end got fc=%0d busy=%b want fc=1 busy=0", o_frame_count, o_busy);
        end
    endtask

    task automatic test_stall();
        vec_t prev;
        bit   prev_stall;
        int   vcyc;
        fill_random();
        prev_stall = 0;
        vcyc = 0;
        prev = '0;
        for (int c = 0; c < 20; c++) begin
            drive(c == 0, 1, (c >= 1) && (c % 2 == 0), 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL stall c%0d got %h want %h", c, observe(), model_out());
            end
            if (prev_stall) begin
                vectors++;
                if (observe() !== prev) begin
                    miscompares++;
                    $display("FAIL stall_hold c%0d got %h want %h", c, observe(), prev);
                end
            end
            if (o_sink_valid) vcyc++;
            prev_stall = o_sink_valid && !i_sink_ready;
            prev = observe();
            advance();
        end
        vectors++;
        if (vcyc !== 16) begin
            miscompares++;
            $display("FAIL stall_len got %0d want 16", vcyc);
        end
    endtask

    task automatic test_overrun();
        fill_random();
        for (int c = 0; c < 20; c++) begin
            drive(c == 0 || c == 4, 1, 1, 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL overrun c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
        end
        vectors++;
        if (o_overrun !== 1'b1 || o_drop_count !== 16'd1) begin
            miscompares++;
            $display("FAIL overrun_flags got ovr=%b drops=%0d want 1 1", o_overrun, o_drop_count);
        end
    endtask

    task automatic test_eop_start();
        int base;
        fill_random();
        base = m_frames;
        for (int c = 0; c < 19; c++) begin
            drive(c == 0 || c == 8, 1, 1, c == 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL eop_start c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
        end
        vectors++;
        if (o_frame_count !== CW'(base + 2) || o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL eop_start_end got fc=%0d ovr=%b want fc=%0d ovr=0", o_frame_count, o_overrun, base + 2);
        end
    endtask

    task automatic test_enable();
        fill_random();
        for (int c = 0; c < 26; c++) begin
            drive(c == 1 || c == 4 || c == 7, c == 4 || c == 7, 1'($urandom), 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL enable c%0d got %h want %h", c, observe(), model_out());
            end
            if (c == 3) begin
                vectors++;
                if (o_sink_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL enable_idle got valid=%b want 0", o_sink_valid);
                end
            end
            advance();
        end
        for (int c = 0; c < 30; c++) begin
            drive(0, 0, 1, 0, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL enable_drain c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
        end
    endtask

    task automatic test_clear();
        fill_random();
        for (int c = 0; c < 20; c++) begin
            drive(c == 0 || c == 3, 1, 1, c == 3 || c == 12, 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL clear c%0d got %h want %h", c, observe(), model_out());
            end
            if (c == 4) begin
                vectors++;
                if (o_overrun !== 1'b0 || o_drop_count !== 16'd0) begin
                    miscompares++;
                    $display("FAIL clear_prio got ovr=%b drops=%0d want 0 0", o_overrun, o_drop_count);
                end
            end
            advance();
        end
    endtask

    task automatic test_mid_reset();
        fill_random();
        for (int c = 0; c < 9; c++) begin
            drive(c == 0 || c == 2, 1, 1, 0, c == 5);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL mid_reset c%0d got %h want %h", c, observe(), model_out());
            end
            if (c == 6) begin
                vectors++;
                if (o_sink_valid !== 1'b0 || o_frame_count !== 16'd0 || o_drop_count !== 16'd0) begin
                    miscompares++;
                    $display("FAIL mid_reset_vals got v=%b fc=%0d dc=%0d want 0 0 0", o_sink_valid, o_frame_count, o_drop_count);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        fill_random();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 249) == 0);
            @(negedge clk);
            vectors++;
            if (observe() !== model_out()) begin
                miscompares++;
                $display("FAIL random c%0d got %h want %h", c, observe(), model_out());
            end
            advance();
            if (c % 100 == 99 && !m_active) fill_random();
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 1);
        m_active = 0; m_beat = 0; m_queued = 0; m_bad = 0;
        m_ovr = 0; m_frames = 0; m_drops = 0;
        fill_random();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_frame();
        test_stall();
        test_overrun();
        test_eop_start();
        test_enable();
        test_clear();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
